// File: rtl/mem_stage_lsu_if.sv
// Data-memory bus between the load/store unit (master) and the data memory (slave).
interface mem_stage_lsu_if;
  logic [31:0] ALUOut_M;
  logic [31:0] WriteData_M;
  logic        MemWrite_M;
  logic [3:0]  BE;
  logic [31:0] ReadData_M;

  modport master (
    output ALUOut_M, WriteData_M, MemWrite_M, BE,
    input  ReadData_M
  );

  modport slave (
    input  ALUOut_M, WriteData_M, MemWrite_M, BE,
    output ReadData_M
  );
endinterface

// File: rtl/mem_stage_lsu.sv
// Load/store unit: E/M and M/W pipeline registers, byte enables and load extraction.
// Optional misaligned-address exceptions are enabled by defining LSU_ADDR_EXC_EN.
module mem_stage_lsu #(
  parameter logic [4:0] EXC_ADEL = 5'd4,
  parameter logic [4:0] EXC_ADES = 5'd5
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [31:0]             ALUOut_E,
  input  logic [31:0]             WriteData_E,
  input  logic                    MemRead_E,
  input  logic                    MemWrite_E,
  input  logic [1:0]              MemSize_E,
  input  logic                    LoadUns_E,
  input  logic                    RegWrite_E,
  input  logic [4:0]              WriteReg_E,
  input  logic                    stall_M,
  input  logic                    flush_M,
  mem_stage_lsu_if.master         dmem,
  output logic                    exc_M,
  output logic [4:0]              exc_code_M,
  output logic [31:0]             Result_W,
  output logic                    RegWrite_W,
  output logic [4:0]              WriteReg_W
);

  logic [31:0] alu_m, wdata_m;
  logic        read_m, write_m, uns_m, regwr_m;
  logic [1:0]  size_m;
  logic [4:0]  wreg_m;

  logic [31:0] alu_w, rdata_w;
  logic        load_w, uns_w, regwr_w;
  logic [1:0]  size_w;
  logic [4:0]  wreg_w;

  logic        mis_store, mis_load;
  logic [3:0]  be_raw;
  logic [15:0] ld_half;
  logic [7:0]  ld_byte;

  // flush_M has priority over stall_M
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      alu_m   <= '0;
      wdata_m <= '0;
      read_m  <= 1'b0;
      write_m <= 1'b0;
      size_m  <= '0;
      uns_m   <= 1'b0;
      regwr_m <= 1'b0;
      wreg_m  <= '0;
    end else if (flush_M) begin
      alu_m   <= '0;
      wdata_m <= '0;
      read_m  <= 1'b0;
      write_m <= 1'b0;
      size_m  <= '0;
      uns_m   <= 1'b0;
      regwr_m <= 1'b0;
      wreg_m  <= '0;
    end else if (!stall_M) begin
      alu_m   <= ALUOut_E;
      wdata_m <= WriteData_E;
      read_m  <= MemRead_E;
      write_m <= MemWrite_E;
      size_m  <= MemSize_E;
      uns_m   <= LoadUns_E;
      regwr_m <= RegWrite_E;
      wreg_m  <= WriteReg_E;
    end
  end

`ifdef LSU_ADDR_EXC_EN
  logic misaligned;
  always_comb begin
    misaligned = 1'b0;
    if (size_m == 2'b01)
      misaligned = alu_m[0];
    else if (size_m != 2'b10)
      misaligned = (alu_m[1:0] != 2'b00);
    mis_store = write_m & misaligned;
    mis_load  = read_m & misaligned;
  end
`else
  // Without exceptions the low address bits the access size cannot use are ignored.
  assign mis_store = 1'b0;
  assign mis_load  = 1'b0;
`endif

  always_comb begin
    be_raw = 4'b1111;
    if (size_m == 2'b01)
      be_raw = alu_m[1] ? 4'b1100 : 4'b0011;
    else if (size_m == 2'b10)
      be_raw = 4'b0001 << alu_m[1:0];
  end

  assign dmem.ALUOut_M    = alu_m;
  assign dmem.WriteData_M = wdata_m;
  assign dmem.MemWrite_M  = write_m & ~mis_store;
  assign dmem.BE          = (write_m & ~mis_store) ? be_raw : 4'b0000;

  assign exc_M      = mis_store | mis_load;
  assign exc_code_M = mis_store ? EXC_ADES : (mis_load ? EXC_ADEL : 5'd0);

  // A stalled M stage sends a bubble down to W
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      alu_w   <= '0;
      rdata_w <= '0;
      load_w  <= 1'b0;
      size_w  <= '0;
      uns_w   <= 1'b0;
      regwr_w <= 1'b0;
      wreg_w  <= '0;
    end else if (stall_M) begin
      alu_w   <= '0;
      rdata_w <= '0;
      load_w  <= 1'b0;
      size_w  <= '0;
      uns_w   <= 1'b0;
      regwr_w <= 1'b0;
      wreg_w  <= '0;
    end else begin
      alu_w   <= alu_m;
      rdata_w <= dmem.ReadData_M;
      load_w  <= read_m;
      size_w  <= size_m;
      uns_w   <= uns_m;
      regwr_w <= regwr_m & ~mis_load;
      wreg_w  <= wreg_m;
    end
  end

  always_comb begin
    ld_half = alu_w[1] ? rdata_w[31:16] : rdata_w[15:0];
    case (alu_w[1:0])
      2'd0:    ld_byte = rdata_w[7:0];
      2'd1:    ld_byte = rdata_w[15:8];
      2'd2:    ld_byte = rdata_w[23:16];
      default: ld_byte = rdata_w[31:24];
    endcase
    if (!load_w)
      Result_W = alu_w;
    else if (size_w == 2'b01)
      Result_W = {{16{~uns_w & ld_half[15]}}, ld_half};
    else if (size_w == 2'b10)
      Result_W = {{24{~uns_w & ld_byte[7]}}, ld_byte};
    else
      Result_W = rdata_w;
  end

  assign RegWrite_W = regwr_w;
  assign WriteReg_W = wreg_w;

endmodule

// File: tb/tb_mem_stage_lsu.sv
// Self-checking bench for mem_stage_lsu: directed scenarios plus randomized ops
// against a byte-addressed reference memory model.
module tb_mem_stage_lsu;

`ifdef LSU_ADDR_EXC_EN
  localparam bit EXC_EN = 1'b1;
`else
  localparam bit EXC_EN = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] ALUOut_E, WriteData_E;
  logic        MemRead_E, MemWrite_E, LoadUns_E, RegWrite_E;
  logic [1:0]  MemSize_E;
  logic [4:0]  WriteReg_E;
  logic        stall_M, flush_M;
  logic        exc_M;
  logic [4:0]  exc_code_M;
  logic [31:0] Result_W;
  logic        RegWrite_W;
  logic [4:0]  WriteReg_W;

  int passed = 0;
  int total  = 0;

  always #5 clk = ~clk;

  mem_stage_lsu_if dmem ();

  mem_stage_lsu #(.EXC_ADEL(5'd4), .EXC_ADES(5'd5)) dut (
    .clk(clk), .reset(reset),
    .ALUOut_E(ALUOut_E), .WriteData_E(WriteData_E),
    .MemRead_E(MemRead_E), .MemWrite_E(MemWrite_E),
    .MemSize_E(MemSize_E), .LoadUns_E(LoadUns_E),
    .RegWrite_E(RegWrite_E), .WriteReg_E(WriteReg_E),
    .stall_M(stall_M), .flush_M(flush_M),
    .dmem(dmem),
    .exc_M(exc_M), .exc_code_M(exc_code_M),
    .Result_W(Result_W), .RegWrite_W(RegWrite_W), .WriteReg_W(WriteReg_W)
  );

  // Data memory: 16 words; store data arrives unshifted and is steered to the enabled lanes.
  logic [31:0] dmem_words [16];
  assign dmem.ReadData_M = dmem_words[dmem.ALUOut_M[5:2]];

  function automatic logic [7:0] lane_data(input logic [31:0] wd, input logic [3:0] be, input int unsigned i);
    int unsigned n;
    n = $countones(be);
    if (n == 4) return wd[8*i +: 8];
    if (n == 2) return wd[8*(i%2) +: 8];
    return wd[7:0];
  endfunction

  always @(posedge clk) begin : mem_write
    logic [31:0] w;
    if (dmem.MemWrite_M) begin
      w = dmem_words[dmem.ALUOut_M[5:2]];
      for (int unsigned i = 0; i < 4; i++)
        if (dmem.BE[i]) w[8*i +: 8] = lane_data(dmem.WriteData_M, dmem.BE, i);
      dmem_words[dmem.ALUOut_M[5:2]] <= w;
    end
  end

  // Reference model: byte-addressed memory and access rules
  logic [7:0] ref_mem [64];

  function automatic int unsigned nbytes(input logic [1:0] sz);
    return (sz == 2'b01) ? 2 : (sz == 2'b10) ? 1 : 4;
  endfunction

  function automatic bit ref_misaligned(input logic [5:0] a, input logic [1:0] sz);
    return (a % nbytes(sz)) != 0;
  endfunction

  function automatic logic [5:0] ref_start(input logic [5:0] a, input logic [1:0] sz);
    return a - (a % nbytes(sz));
  endfunction

  function automatic logic [3:0] ref_be(input logic [5:0] a, input logic [1:0] sz);
    logic [3:0] be;
    int unsigned s;
    be = '0;
    s = ref_start(a, sz) % 4;
    for (int unsigned k = 0; k < nbytes(sz); k++) be[s + k] = 1'b1;
    return be;
  endfunction

  function automatic logic [31:0] ref_load(input logic [5:0] a, input logic [1:0] sz, input logic uns);
    logic [31:0] v;
    int unsigned n, s;
    n = nbytes(sz);
    s = ref_start(a, sz);
    v = '0;
    for (int unsigned k = 0; k < n; k++) v = v | (32'(ref_mem[s + k]) << (8 * k));
    if (!uns && n < 4 && v[8*n - 1]) v = v | ~((32'd1 << (8 * n)) - 32'd1);
    return v;
  endfunction

  task automatic ref_store(input logic [5:0] a, input logic [1:0] sz, input logic [31:0] d);
    int unsigned s;
    s = ref_start(a, sz);
    for (int unsigned k = 0; k < nbytes(sz); k++) ref_mem[s + k] = d[8*k +: 8];
  endtask

  task automatic drive(input logic rd, input logic wr, input logic [1:0] sz, input logic uns,
                       input logic rw, input logic [4:0] rg, input logic [31:0] addr, input logic [31:0] data);
    MemRead_E = rd; MemWrite_E = wr; MemSize_E = sz; LoadUns_E = uns;
    RegWrite_E = rw; WriteReg_E = rg; ALUOut_E = addr; WriteData_E = data;
  endtask

  task automatic idle();
    drive(1'b0, 1'b0, 2'b00, 1'b0, 1'b0, 5'd0, 32'd0, 32'd0);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    drive(1'b0, 1'b1, 2'b00, 1'b0, 1'b1, 5'd3, 32'h10, 32'hDEADBEEF);
    tick();
    tick();
    total++;
    if ({dmem.ALUOut_M, dmem.WriteData_M, dmem.MemWrite_M, dmem.BE, exc_M, exc_code_M,
         Result_W, RegWrite_W, WriteReg_W} !== '0)
      $display("FAIL reset_outputs: MemWrite_M=%b BE=%b ALUOut_M=%h Result_W=%h RegWrite_W=%b, required all 0",
               dmem.MemWrite_M, dmem.BE, dmem.ALUOut_M, Result_W, RegWrite_W);
    else passed++;
    idle();
    @(negedge clk);
    reset = 1'b1;
    tick();
  endtask

  task automatic test_sw_lw();
    drive(1'b0, 1'b1, 2'b00, 1'b0, 1'b0, 5'd0, 32'h10, 32'hA1B2C3D4);
    tick();
    total++;
    if ({dmem.MemWrite_M, dmem.BE} !== 5'b1_1111)
      $display("FAIL sw_strobe: MemWrite_M/BE=%b/%b, required 1/1111", dmem.MemWrite_M, dmem.BE);
    else passed++;
    drive(1'b1, 1'b0, 2'b00, 1'b0, 1'b1, 5'd5, 32'h10, 32'd0);
    tick();
    idle();
    tick();
    total++;
    if ({Result_W, RegWrite_W, WriteReg_W} !== {32'hA1B2C3D4, 1'b1, 5'd5})
      $display("FAIL lw_result: Result_W=%h RegWrite_W=%b WriteReg_W=%0d, required a1b2c3d4 1 5",
               Result_W, RegWrite_W, WriteReg_W);
    else passed++;
  endtask

  task automatic test_sb_lb();
    drive(1'b0, 1'b1, 2'b10, 1'b0, 1'b0, 5'd0, 32'h13, 32'h000000F0);
    tick();
    total++;
    if ({dmem.MemWrite_M, dmem.BE} !== 5'b1_1000)
      $display("FAIL sb_be: MemWrite_M/BE=%b/%b, required 1/1000", dmem.MemWrite_M, dmem.BE);
    else passed++;
    drive(1'b1, 1'b0, 2'b10, 1'b0, 1'b1, 5'd8, 32'h13, 32'd0);
    tick();
    drive(1'b1, 1'b0, 2'b10, 1'b1, 1'b1, 5'd9, 32'h13, 32'd0);
    tick();
    total++;
    if (Result_W !== 32'hFFFFFFF0)
      $display("FAIL lb_result: Result_W=%h, required fffffff0", Result_W);
    else passed++;
    idle();
    tick();
    total++;
    if (Result_W !== 32'h000000F0)
      $display("FAIL lbu_result: Result_W=%h, required 000000f0", Result_W);
    else passed++;
  endtask

  task automatic test_sh_lh();
    drive(1'b0, 1'b1, 2'b01, 1'b0, 1'b0, 5'd0, 32'h12, 32'h00008001);
    tick();
    total++;
    if ({dmem.MemWrite_M, dmem.BE} !== 5'b1_1100)
      $display("FAIL sh_be: MemWrite_M/BE=%b/%b, required 1/1100", dmem.MemWrite_M, dmem.BE);
    else passed++;
    drive(1'b1, 1'b0, 2'b01, 1'b0, 1'b1, 5'd10, 32'h12, 32'd0);
    tick();
    drive(1'b1, 1'b0, 2'b01, 1'b1, 1'b1, 5'd11, 32'h12, 32'd0);
    tick();
    total++;
    if (Result_W !== 32'hFFFF8001)
      $display("FAIL lh_result: Result_W=%h, required ffff8001", Result_W);
    else passed++;
    idle();
    tick();
    total++;
    if (Result_W !== 32'h00008001)
      $display("FAIL lhu_result: Result_W=%h, required 00008001", Result_W);
    else passed++;
  endtask

  task automatic test_stall();
    drive(1'b0, 1'b1, 2'b00, 1'b0, 1'b0, 5'd0, 32'h20, 32'h12345678);
    tick();
    drive(1'b1, 1'b0, 2'b00, 1'b0, 1'b1, 5'd7, 32'h20, 32'd0);
    tick();
    stall_M = 1'b1;
    drive(1'b0, 1'b1, 2'b00, 1'b0, 1'b1, 5'd2, 32'h24, 32'hFFFFFFFF);
    for (int c = 0; c < 2; c++) begin
      tick();
      total++;
      if ({dmem.ALUOut_M, dmem.MemWrite_M, RegWrite_W} !== {32'h20, 1'b0, 1'b0})
        $display("FAIL stall_hold_%0d: ALUOut_M=%h MemWrite_M=%b RegWrite_W=%b, required 00000020 0 0",
                 c, dmem.ALUOut_M, dmem.MemWrite_M, RegWrite_W);
      else passed++;
    end
    stall_M = 1'b0;
    idle();
    tick();
    total++;
    if ({Result_W, RegWrite_W, WriteReg_W} !== {32'h12345678, 1'b1, 5'd7})
      $display("FAIL stall_release: Result_W=%h RegWrite_W=%b WriteReg_W=%0d, required 12345678 1 7",
               Result_W, RegWrite_W, WriteReg_W);
    else passed++;
  endtask

  task automatic test_stall_flush();
    drive(1'b0, 1'b1, 2'b00, 1'b0, 1'b1, 5'd4, 32'h30, 32'h0BADF00D);
    tick();
    stall_M = 1'b1;
    flush_M = 1'b1;
    tick();
    total++;
    if ({dmem.ALUOut_M, dmem.WriteData_M, dmem.MemWrite_M, dmem.BE} !== '0)
      $display("FAIL stall_flush_zero: ALUOut_M=%h WriteData_M=%h MemWrite_M=%b BE=%b, required all 0",
               dmem.ALUOut_M, dmem.WriteData_M, dmem.MemWrite_M, dmem.BE);
    else passed++;
    stall_M = 1'b0;
    flush_M = 1'b0;
    idle();
    tick();
  endtask

  task automatic test_misaligned();
    drive(1'b0, 1'b1, 2'b00, 1'b0, 1'b0, 5'd0, 32'h11, 32'hCAFEBABE);
    tick();
`ifdef LSU_ADDR_EXC_EN
    total++;
    if ({exc_M, exc_code_M, dmem.BE, dmem.MemWrite_M} !== {1'b1, 5'd5, 4'b0000, 1'b0})
      $display("FAIL mis_store_exc: exc_M=%b code=%0d BE=%b MemWrite_M=%b, required 1 5 0000 0",
               exc_M, exc_code_M, dmem.BE, dmem.MemWrite_M);
    else passed++;
    drive(1'b1, 1'b0, 2'b00, 1'b0, 1'b1, 5'd12, 32'h11, 32'd0);
    tick();
    total++;
    if ({exc_M, exc_code_M} !== {1'b1, 5'd4})
      $display("FAIL mis_load_exc: exc_M=%b code=%0d, required 1 4", exc_M, exc_code_M);
    else passed++;
    idle();
    tick();
    total++;
    if (RegWrite_W !== 1'b0)
      $display("FAIL mis_load_regwrite: RegWrite_W=%b, required 0", RegWrite_W);
    else passed++;
`else
    total++;
    if ({exc_M, exc_code_M, dmem.BE, dmem.MemWrite_M, dmem.ALUOut_M[31:2]} !==
        {1'b0, 5'd0, 4'b1111, 1'b1, 30'h4})
      $display("FAIL mis_store_noexc: exc_M=%b code=%0d BE=%b MemWrite_M=%b word=%h, required 0 0 1111 1 4",
               exc_M, exc_code_M, dmem.BE, dmem.MemWrite_M, dmem.ALUOut_M[31:2]);
    else passed++;
    drive(1'b1, 1'b0, 2'b01, 1'b0, 1'b1, 5'd12, 32'h13, 32'd0);
    tick();
    total++;
    if (exc_M !== 1'b0)
      $display("FAIL mis_load_noexc: exc_M=%b, required 0", exc_M);
    else passed++;
    idle();
    tick();
    total++;
    if ({Result_W, RegWrite_W} !== {32'hFFFFCAFE, 1'b1})
      $display("FAIL mis_half_result: Result_W=%h RegWrite_W=%b, required ffffcafe 1", Result_W, RegWrite_W);
    else passed++;
`endif
  endtask

  task automatic test_reset_mid_store();
    logic [31:0] prev;
    prev = dmem_words[6];
    drive(1'b0, 1'b1, 2'b00, 1'b0, 1'b0, 5'd0, 32'h18, ~prev);
    tick();
    total++;
    if (dmem.MemWrite_M !== 1'b1)
      $display("FAIL mid_store_pre: MemWrite_M=%b, required 1", dmem.MemWrite_M);
    else passed++;
    idle();
    #2;
    reset = 1'b0;
    #1;
    total++;
    if ({dmem.MemWrite_M, dmem.BE} !== 5'b0)
      $display("FAIL mid_store_async: MemWrite_M/BE=%b/%b, required 0/0000", dmem.MemWrite_M, dmem.BE);
    else passed++;
    tick();
    total++;
    if (dmem_words[6] !== prev)
      $display("FAIL mid_store_dropped: mem[0x18]=%h, required %h", dmem_words[6], prev);
    else passed++;
    @(negedge clk);
    reset = 1'b1;
    tick();
  endtask

  task automatic test_random();
    logic [31:0] a, d, exp_res;
    logic [1:0]  sz;
    logic        uns, rw, bad;
    logic [4:0]  rg;
    int unsigned kind;
    logic        pend_valid, pend_rw, pend_chk;
    logic [4:0]  pend_reg;
    logic [31:0] pend_res;
    logic [3:0]  exp_be;
    logic        exp_mw, exp_exc;
    logic [4:0]  exp_code;

    for (int unsigned w = 0; w < 16; w++)
      for (int unsigned k = 0; k < 4; k++) ref_mem[4*w + k] = dmem_words[w][8*k +: 8];
    pend_valid = 1'b0; pend_rw = 1'b0; pend_chk = 1'b0; pend_reg = '0; pend_res = '0;

    for (int it = 0; it < 300; it++) begin
      kind = $urandom_range(2, 0);
      a    = $urandom();
      d    = $urandom();
      sz   = 2'($urandom_range(3, 0));
      uns  = 1'($urandom_range(1, 0));
      rw   = 1'($urandom_range(1, 0));
      rg   = 5'($urandom_range(31, 0));
      drive(kind == 1, kind == 2, sz, uns, rw, rg, a, d);
      tick();

      bad      = EXC_EN && ref_misaligned(a[5:0], sz);
      exp_mw   = (kind == 2) && !bad;
      exp_be   = exp_mw ? ref_be(a[5:0], sz) : 4'b0000;
      exp_exc  = (kind != 0) && bad;
      exp_code = !exp_exc ? 5'd0 : (kind == 2) ? 5'd5 : 5'd4;

      total++;
      if ({dmem.MemWrite_M, dmem.BE, exc_M, exc_code_M} !== {exp_mw, exp_be, exp_exc, exp_code})
        $display("FAIL rnd_m_ctrl[%0d]: MemWrite_M=%b BE=%b exc=%b code=%0d, required %b %b %b %0d (a=%h sz=%0d)",
                 it, dmem.MemWrite_M, dmem.BE, exc_M, exc_code_M, exp_mw, exp_be, exp_exc, exp_code, a, sz);
      else passed++;
      total++;
      if ({dmem.ALUOut_M, dmem.WriteData_M} !== {a, d})
        $display("FAIL rnd_m_bus[%0d]: ALUOut_M=%h WriteData_M=%h, required %h %h",
                 it, dmem.ALUOut_M, dmem.WriteData_M, a, d);
      else passed++;

      if (pend_valid) begin
        total++;
        if ({RegWrite_W, WriteReg_W} !== {pend_rw, pend_reg})
          $display("FAIL rnd_w_ctrl[%0d]: RegWrite_W=%b WriteReg_W=%0d, required %b %0d",
                   it, RegWrite_W, WriteReg_W, pend_rw, pend_reg);
        else passed++;
        if (pend_chk) begin
          total++;
          if (Result_W !== pend_res)
            $display("FAIL rnd_w_result[%0d]: Result_W=%h, required %h", it, Result_W, pend_res);
          else passed++;
        end
      end

      exp_res    = (kind == 1) ? ref_load(a[5:0], sz, uns) : a;
      pend_valid = 1'b1;
      pend_rw    = rw && !((kind == 1) && bad);
      pend_chk   = !((kind == 1) && bad);
      pend_reg   = rg;
      pend_res   = exp_res;
      if (kind == 2 && !bad) ref_store(a[5:0], sz, d);
    end
    idle();
    tick();
  endtask

  initial begin
    reset = 1'b0;
    stall_M = 1'b0;
    flush_M = 1'b0;
    idle();
    test_reset();
    test_sw_lw();
    test_sb_lb();
    test_sh_lh();
    test_stall();
    test_stall_flush();
    test_misaligned();
    test_reset_mid_store();
    test_random();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
